output_sram_arbiter: RTL and testbench

Downstream consumer of the vertex buffer banks. Each cycle it picks at most one bank write request with a round-robin policy, returns the one-hot `req_grant` to the banks, and issues a single registered write to the output SRAM. It also runs a drain handshake for the layer controller: once every bank is empty and the write pipe has retired, it reports flush completion.

---
 rtl/output_sram_arbiter_pkg.sv | 25 ++
 rtl/output_sram_arbiter_rr_arbiter.sv | 32 +++
 rtl/output_sram_arbiter.sv | 123 ++++++++++++
 tb/tb_output_sram_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/output_sram_arbiter_pkg.sv
// Shared definitions for the output SRAM arbiter: bank request packet,
// project-wide sizes and the drain FSM state type.
package output_sram_arbiter_pkg;

  localparam int NUM_VERTEX_UNIT = 4;
  localparam int OSRAM_ADDR_W    = 8;
  localparam int OSRAM_DATA_W    = 64;

  typedef struct packed {
    logic                    req;
    logic [OSRAM_ADDR_W-1:0] addr;
    logic [OSRAM_DATA_W-1:0] data;
  } bank_req2req_output_sram_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } arb_state_e;

  // Width of a port index; a single-port build still needs a 1-bit pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_sram_arbiter_rr_arbiter.sv
// Combinational round-robin search: first requester at or above rr_ptr,
// wrapping past the top port, wins.
module rr_arbiter
  import output_sram_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = NUM_VERTEX_UNIT,
  parameter int PTR_W     = ptr_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PTR_W-1:0]     winner,
  output logic                 valid
);

  always_comb begin
    int idx;
    idx    = 0;
    grant  = '0;
    winner = '0;
    valid  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_PORTS;
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        winner     = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/output_sram_arbiter.sv
// Round-robin arbiter from the vertex buffer banks to the output SRAM write
// port, with a registered write stage and a flush/drain handshake.
module output_sram_arbiter
  import output_sram_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = NUM_VERTEX_UNIT,
  parameter int ADDR_W    = OSRAM_ADDR_W,
  parameter int DATA_W    = OSRAM_DATA_W
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  bank_req2req_output_sram_t [NUM_PORTS-1:0] outbuff_pkt,
  input  logic                                      buffer_empty,
  input  logic                                      sram_stall,
  input  logic                                      flush_req,
  output logic [NUM_PORTS-1:0]                      req_grant,
  output logic                                      sram_wen,
  output logic [ADDR_W-1:0]                         sram_addr,
  output logic [DATA_W-1:0]                         sram_wdata,
  output logic                                      flush_done,
  output logic                                      busy,
  output logic [15:0]                               wr_count
);

  localparam int PTR_W = ptr_width(NUM_PORTS);

  logic [NUM_PORTS-1:0] bank_req;
  logic [NUM_PORTS-1:0] arb_req;
  logic [NUM_PORTS-1:0] grant;
  logic [PTR_W-1:0]     winner;
  logic                 transfer;
  logic                 drain_ok;
  bank_req2req_output_sram_t winner_pkt;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              sram_wen_q, sram_wen_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  logic [15:0]       wr_count_q, wr_count_d;
  arb_state_e        state_q, state_d;
  logic              flush_done_c;

  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      bank_req[k] = outbuff_pkt[k].req;
    end
  end

  // Reset is folded in so nothing is granted while the block is held in reset.
  assign arb_req = (reset && !sram_stall) ? bank_req : '0;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_rr_arbiter (
    .req    (arb_req),
    .rr_ptr (rr_ptr_q),
    .grant  (grant),
    .winner (winner),
    .valid  (transfer)
  );

  assign winner_pkt = outbuff_pkt[winner];
  assign drain_ok   = buffer_empty && (bank_req == '0) && !sram_wen_q && !transfer;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    sram_wen_d   = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    wr_count_d   = wr_count_q;
    state_d      = state_q;
    flush_done_c = 1'b0;

    if (transfer) begin
      rr_ptr_d     = (winner == PTR_W'(NUM_PORTS - 1)) ? '0 : winner + PTR_W'(1);
      sram_wen_d   = 1'b1;
      sram_addr_d  = ADDR_W'(winner_pkt.addr);
      sram_wdata_d = DATA_W'(winner_pkt.data);
      wr_count_d   = wr_count_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (flush_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_ok) begin
          state_d      = ST_IDLE;
          flush_done_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q     <= '0;
      sram_wen_q   <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      wr_count_q   <= '0;
      state_q      <= ST_IDLE;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      sram_wen_q   <= sram_wen_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      wr_count_q   <= wr_count_d;
      state_q      <= state_d;
    end
  end

  assign req_grant  = grant;
  assign sram_wen   = sram_wen_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign wr_count   = wr_count_q;
  assign busy       = (state_q == ST_DRAIN);
  assign flush_done = flush_done_c;

endmodule

// File: tb/tb_output_sram_arbiter.sv
// Directed plus randomized bench for output_sram_arbiter against a
// cycle-level reference model of the grant, write and drain rules.
module tb_output_sram_arbiter;
  import output_sram_arbiter_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bank_req2req_output_sram_t [N-1:0] outbuff_pkt;
  logic [N-1:0] req_in;
  logic [7:0]   addr_in [N];
  logic [63:0]  data_in [N];
  logic         buffer_empty, sram_stall, flush_req;
  logic [N-1:0] req_grant;
  logic         sram_wen, flush_done, busy;
  logic [7:0]   sram_addr;
  logic [63:0]  sram_wdata;
  logic [15:0]  wr_count;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      outbuff_pkt[k].req  = req_in[k];
      outbuff_pkt[k].addr = addr_in[k];
      outbuff_pkt[k].data = data_in[k];
    end
  end

  output_sram_arbiter #(.NUM_PORTS(N), .ADDR_W(8), .DATA_W(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .outbuff_pkt  (outbuff_pkt),
    .buffer_empty (buffer_empty),
    .sram_stall   (sram_stall),
    .flush_req    (flush_req),
    .req_grant    (req_grant),
    .sram_wen     (sram_wen),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .flush_done   (flush_done),
    .busy         (busy),
    .wr_count     (wr_count)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  int           m_ptr;
  logic         m_wen;
  logic [7:0]   m_addr;
  logic [63:0]  m_data;
  logic [15:0]  m_count;
  logic         m_busy;
  logic [N-1:0] m_grant;
  int           m_win;
  logic         m_done;
  int           wait_c [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_wen = 1'b0; m_addr = '0; m_data = '0; m_count = '0; m_busy = 1'b0;
    m_grant = '0; m_win = -1; m_done = 1'b0;
    for (int k = 0; k < N; k++) wait_c[k] = 0;
  endtask

  // Winner: first requesting port reached walking upward from the pointer.
  task automatic model_eval();
    m_grant = '0;
    m_win   = -1;
    if (!sram_stall) begin
      for (int d = N - 1; d >= 0; d--) begin
        if (req_in[(m_ptr + d) % N]) m_win = (m_ptr + d) % N;
      end
    end
    if (m_win >= 0) m_grant[m_win] = 1'b1;
    m_done = m_busy && buffer_empty && (req_in == '0) && !m_wen && (m_win < 0);
  endtask

  task automatic model_clock();
    if (m_win >= 0) begin
      m_wen   = 1'b1;
      m_addr  = addr_in[m_win];
      m_data  = data_in[m_win];
      m_count = m_count + 16'd1;
      m_ptr   = (m_win + 1) % N;
    end else begin
      m_wen = 1'b0;
    end
    if (!m_busy && flush_req) m_busy = 1'b1;
    else if (m_done)          m_busy = 1'b0;
  endtask

  task automatic check_all();
    chk("req_grant",  req_grant,  m_grant);
    chk("sram_wen",   sram_wen,   m_wen);
    chk("sram_addr",  sram_addr,  m_addr);
    chk("sram_wdata", sram_wdata, m_data);
    chk("wr_count",   wr_count,   m_count);
    chk("busy",       busy,       m_busy);
    chk("flush_done", flush_done, m_done);
  endtask

  // One clock: inputs are stable from the preceding negedge.
  task automatic step();
    #1;
    model_eval();
    check_all();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_grant"}, req_grant,  '0);
    chk({tag, "_wen"},   sram_wen,   1'b0);
    chk({tag, "_addr"},  sram_addr,  '0);
    chk({tag, "_data"},  sram_wdata, '0);
    chk({tag, "_count"}, wr_count,   '0);
    chk({tag, "_busy"},  busy,       1'b0);
    chk({tag, "_done"},  flush_done, 1'b0);
  endtask

  initial begin
    reset = 1'b0; req_in = '1; buffer_empty = 1'b1; sram_stall = 1'b0; flush_req = 1'b0;
    for (int k = 0; k < N; k++) begin
      addr_in[k] = 8'h10 + 8'(k);
      data_in[k] = {32'hD00D0000 + 32'(k), 32'h0000BEE0 + 32'(k)};
    end
    model_reset();
    @(negedge clk); @(negedge clk);
    #1 check_reset_values("reset");
    @(negedge clk);
    req_in = '0;
    reset = 1'b1;

    // all four ports request continuously: grants rotate 0,1,2,3,...
    req_in = 4'hF;
    repeat (8) step();
    req_in = '0;
    #1 chk("t1_wr_count_8", wr_count, 16'd8);
    step();

    // single requester on port 2
    req_in = 4'b0100; addr_in[2] = 8'h15; data_in[2] = 64'hAAAA_AAAA_AAAA_AAAA;
    step();
    req_in = '0;
    #1 chk("t2_addr", sram_addr, 8'h15);
    step();

    // port 3 moves the pointer back to 0, then ports 1 and 3 under stall
    req_in = 4'b1000;
    step();
    req_in = 4'b1010; sram_stall = 1'b1;
    repeat (3) step();
    sram_stall = 1'b0;
    #1 chk("t3_first_unstalled", req_grant, 4'b0010);
    step();
    req_in = '0;
    step();

    // flush with two ports pending and the buffer not yet empty
    req_in = 4'b0101; buffer_empty = 1'b0; flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_in = req_in & ~m_grant;
      step();
    end
    buffer_empty = 1'b1;
    repeat (3) step();

    // flush when already empty, then a repeated flush during a held drain
    step();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    #1 chk("t5_done_1cycle", flush_done, 1'b1);
    step();
    buffer_empty = 1'b0; flush_req = 1'b1;
    step();
    step();
    flush_req = 1'b0;
    step();
    buffer_empty = 1'b1;
    step();
    step();

    // asynchronous reset while a write is in flight
    req_in = 4'b0110;
    step();
    #2 reset = 1'b0;
    #1 check_reset_values("t6_async");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    #1 chk("t6_first_grant", req_grant, 4'b0010);
    step();
    req_in = '0;
    step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        if (m_grant[k] || !req_in[k]) begin
          req_in[k]  = 1'($urandom_range(0, 1));
          addr_in[k] = 8'($urandom);
          data_in[k] = {$urandom, $urandom};
        end
      end
      sram_stall   = ($urandom_range(0, 4) == 0);
      flush_req    = ($urandom_range(0, 15) == 0);
      buffer_empty = ($urandom_range(0, 2) != 0);
      step();
      for (int k = 0; k < N; k++) begin
        if (req_in[k] && !sram_stall) begin
          if (m_grant[k]) begin
            chk("fairness", wait_c[k] < N, 1'b1);
            wait_c[k] = 0;
          end else begin
            wait_c[k]++;
          end
        end
        if (!req_in[k]) wait_c[k] = 0;
      end
    end
    req_in = '0; flush_req = 1'b0; sram_stall = 1'b0; buffer_empty = 1'b1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
